// File: rtl/painterengine_gpu_dma_reader_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : painterengine_gpu_dma_reader_mc                                    |
// | Restartable multi-channel AXI4 burst read DMA; beats stream to the one-hot |
// | selected consumer. Option macro: PAINTERENGINE_GPU_READER_STATS_EN          |
// | Revision: 1.0 - initial parametrised release                               |
// +----------------------------------------------------------------------------+
module painterengine_gpu_dma_reader_mc #(
  parameter int CHANNELS     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int LEN_WIDTH    = 32,
  parameter int MAX_BURST    = 16,
  parameter int TIMEOUT_BITS = 19
) (
  input  logic                           i_wire_clock,
  input  logic                           i_wire_resetn,
  input  logic                           i_wire_start,
  input  logic [CHANNELS-1:0]            i_wire_router,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] i_wire_address,
  input  logic [CHANNELS*LEN_WIDTH-1:0]  i_wire_length,
  output logic                           o_wire_busy,
  output logic                           o_wire_done,
  output logic                           o_wire_error,
  output logic [2:0]                     o_wire_error_type,
  output logic [CHANNELS*DATA_WIDTH-1:0] o_wire_data,
  output logic [CHANNELS-1:0]            o_wire_data_valid,
  input  logic [CHANNELS-1:0]            i_wire_data_next,
  output logic [LEN_WIDTH-1:0]           o_wire_beat_count,
  output logic [0:0]                     o_wire_M_AXI_ARID,
  output logic [ADDR_WIDTH-1:0]          o_wire_M_AXI_ARADDR,
  output logic [7:0]                     o_wire_M_AXI_ARLEN,
  output logic [2:0]                     o_wire_M_AXI_ARSIZE,
  output logic [1:0]                     o_wire_M_AXI_ARBURST,
  output logic                           o_wire_M_AXI_ARLOCK,
  output logic [3:0]                     o_wire_M_AXI_ARCACHE,
  output logic [2:0]                     o_wire_M_AXI_ARPROT,
  output logic [3:0]                     o_wire_M_AXI_ARQOS,
  output logic                           o_wire_M_AXI_ARVALID,
  input  logic                           i_wire_M_AXI_ARREADY,
  input  logic [0:0]                     i_wire_M_AXI_RID,
  input  logic [DATA_WIDTH-1:0]          i_wire_M_AXI_RDATA,
  input  logic [1:0]                     i_wire_M_AXI_RRESP,
  input  logic                           i_wire_M_AXI_RLAST,
  input  logic                           i_wire_M_AXI_RVALID,
  output logic                           o_wire_M_AXI_RREADY
);

  localparam int c_BYTES      = DATA_WIDTH / 8;
  localparam int c_LOG2_BYTES = $clog2(c_BYTES);
  localparam int c_IDX_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_ROUTE = 3'd1;
  localparam logic [2:0] c_CHECK = 3'd2;
  localparam logic [2:0] c_CALC  = 3'd3;
  localparam logic [2:0] c_ADDR  = 3'd4;
  localparam logic [2:0] c_READ  = 3'd5;
  localparam logic [2:0] c_DONE  = 3'd6;
  localparam logic [2:0] c_ERROR = 3'd7;

  localparam logic [2:0] c_ERR_NONE   = 3'd0;
  localparam logic [2:0] c_ERR_ROUTER = 3'd1;
  localparam logic [2:0] c_ERR_ADDR   = 3'd2;
  localparam logic [2:0] c_ERR_AR_TO  = 3'd3;
  localparam logic [2:0] c_ERR_R_TO   = 3'd4;
  localparam logic [2:0] c_ERR_PROTO  = 3'd5;
  localparam logic [2:0] c_ERR_RRESP  = 3'd6;

  logic [2:0]              r_state;
  logic [2:0]              w_state_next;
  logic [2:0]              w_error_code;
  logic [CHANNELS-1:0]     r_router;
  logic [c_IDX_W-1:0]      r_index;
  logic [c_IDX_W-1:0]      w_route_index;
  logic [ADDR_WIDTH-1:0]   r_address;
  logic [LEN_WIDTH-1:0]    r_length;
  logic [LEN_WIDTH-1:0]    r_offset;
  logic [LEN_WIDTH-1:0]    r_blen;
  logic [LEN_WIDTH-1:0]    r_beat;
  logic [ADDR_WIDTH-1:0]   r_araddr;
  logic [7:0]              r_arlen;
  logic [TIMEOUT_BITS-1:0] r_timer;
  logic [2:0]              r_error_type;

  logic                    w_start_ok;
  logic                    w_onehot;
  logic                    w_rready;
  logic                    w_beat;
  logic                    w_ar_hs;
  logic                    w_last_beat;
  logic                    w_timeout;
  logic [LEN_WIDTH-1:0]    w_final_offset;
  logic [LEN_WIDTH-1:0]    w_rem;
  logic [LEN_WIDTH-1:0]    w_pos;
  logic [LEN_WIDTH-1:0]    w_room;
  logic [LEN_WIDTH-1:0]    w_blen;
  logic [ADDR_WIDTH-1:0]   w_calc_addr;
  logic                    w_unused;

  assign w_start_ok = i_wire_start &
                      ((r_state == c_IDLE) | (r_state == c_DONE) | (r_state == c_ERROR));
  assign w_onehot   = (r_router != '0) &&
                      ((r_router & (r_router - CHANNELS'(1))) == '0);
  assign w_rready   = (r_state == c_READ) & i_wire_data_next[r_index];
  assign w_beat     = w_rready & i_wire_M_AXI_RVALID;
  assign w_ar_hs    = (r_state == c_ADDR) & i_wire_M_AXI_ARREADY;
  assign w_last_beat    = (r_beat == r_blen - LEN_WIDTH'(1));
  assign w_final_offset = r_offset + r_blen;
  assign w_timeout      = r_timer[TIMEOUT_BITS-1];
  assign w_unused       = ^i_wire_M_AXI_RID;

  // Burst sized to the room left before the next MAX_BURST-beat aligned boundary.
  assign w_rem       = r_length - r_offset;
  assign w_pos       = LEN_WIDTH'(r_address >> c_LOG2_BYTES) + r_offset;
  assign w_room      = LEN_WIDTH'(MAX_BURST) - (w_pos & LEN_WIDTH'(MAX_BURST - 1));
  assign w_blen      = (w_rem < w_room) ? w_rem : w_room;
  assign w_calc_addr = r_address + (ADDR_WIDTH'(r_offset) << c_LOG2_BYTES);

  always_comb begin
    w_route_index = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (r_router[i]) w_route_index = c_IDX_W'(i);
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) r_state <= c_IDLE;
    else                r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_error_code = c_ERR_NONE;
    case (r_state)
      c_IDLE, c_DONE, c_ERROR: begin
        if (i_wire_start) w_state_next = c_ROUTE;
      end
      c_ROUTE: begin
        if (!w_onehot) begin
          w_state_next = c_ERROR;
          w_error_code = c_ERR_ROUTER;
        end else begin
          w_state_next = c_CHECK;
        end
      end
      c_CHECK: begin
        if ((|r_address[c_LOG2_BYTES-1:0]) || (r_length == '0)) begin
          w_state_next = c_ERROR;
          w_error_code = c_ERR_ADDR;
        end else begin
          w_state_next = c_CALC;
        end
      end
      c_CALC: w_state_next = c_ADDR;
      c_ADDR: begin
        if (i_wire_M_AXI_ARREADY) begin
          w_state_next = c_READ;
        end else if (w_timeout) begin
          w_state_next = c_ERROR;
          w_error_code = c_ERR_AR_TO;
        end
      end
      c_READ: begin
        if (w_beat) begin
          if (i_wire_M_AXI_RRESP != 2'b00) begin
            w_state_next = c_ERROR;
            w_error_code = c_ERR_RRESP;
          end else if (i_wire_M_AXI_RLAST != w_last_beat) begin
            w_state_next = c_ERROR;
            w_error_code = c_ERR_PROTO;
          end else if (w_last_beat) begin
            w_state_next = (w_final_offset == r_length) ? c_DONE : c_CALC;
          end
        end else if (w_timeout) begin
          w_state_next = c_ERROR;
          w_error_code = c_ERR_R_TO;
        end
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    o_wire_busy          = (r_state == c_ROUTE) | (r_state == c_CHECK) | (r_state == c_CALC) |
                           (r_state == c_ADDR)  | (r_state == c_READ);
    o_wire_done          = (r_state == c_DONE);
    o_wire_error         = (r_state == c_ERROR);
    o_wire_M_AXI_ARVALID = (r_state == c_ADDR);
    o_wire_M_AXI_RREADY  = w_rready;
    o_wire_data          = '0;
    o_wire_data_valid    = '0;
    if (r_state == c_READ) begin
      o_wire_data[r_index*DATA_WIDTH +: DATA_WIDTH] = i_wire_M_AXI_RDATA;
      o_wire_data_valid[r_index]                    = i_wire_M_AXI_RVALID;
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      r_router     <= '0;
      r_index      <= '0;
      r_address    <= '0;
      r_length     <= '0;
      r_offset     <= '0;
      r_blen       <= '0;
      r_beat       <= '0;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_timer      <= '0;
      r_error_type <= c_ERR_NONE;
    end else begin
      if (w_start_ok) begin
        r_router     <= i_wire_router;
        r_error_type <= c_ERR_NONE;
      end
      if ((r_state == c_ROUTE) && w_onehot) begin
        r_index   <= w_route_index;
        r_address <= i_wire_address[w_route_index*ADDR_WIDTH +: ADDR_WIDTH];
        r_length  <= i_wire_length[w_route_index*LEN_WIDTH +: LEN_WIDTH];
        r_offset  <= '0;
      end
      if (r_state == c_CALC) begin
        r_blen   <= w_blen;
        r_araddr <= w_calc_addr;
        r_arlen  <= 8'(w_blen - LEN_WIDTH'(1));
        r_beat   <= '0;
      end
      if (w_beat) begin
        r_beat <= r_beat + LEN_WIDTH'(1);
        if (w_last_beat) r_offset <= w_final_offset;
      end
      if ((w_state_next == c_ERROR) && (r_state != c_ERROR)) r_error_type <= w_error_code;
      // Any progress or state change restarts the watchdog.
      if ((w_state_next != r_state) || w_ar_hs || w_beat) begin
        r_timer <= '0;
      end else if ((r_state == c_ADDR) || (r_state == c_READ)) begin
        r_timer <= r_timer + TIMEOUT_BITS'(1);
      end
    end
  end

`ifdef PAINTERENGINE_GPU_READER_STATS_EN
  logic [LEN_WIDTH-1:0] r_beat_count;

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn)  r_beat_count <= '0;
    else if (w_start_ok) r_beat_count <= '0;
    else if (w_beat)     r_beat_count <= r_beat_count + LEN_WIDTH'(1);
  end

  assign o_wire_beat_count = r_beat_count;
`else
  assign o_wire_beat_count = '0;
`endif

  assign o_wire_error_type    = r_error_type;
  assign o_wire_M_AXI_ARID    = 1'b0;
  assign o_wire_M_AXI_ARADDR  = r_araddr;
  assign o_wire_M_AXI_ARLEN   = r_arlen;
  assign o_wire_M_AXI_ARSIZE  = 3'(c_LOG2_BYTES);
  assign o_wire_M_AXI_ARBURST = 2'b01;
  assign o_wire_M_AXI_ARLOCK  = 1'b0;
  assign o_wire_M_AXI_ARCACHE = 4'b0010;
  assign o_wire_M_AXI_ARPROT  = 3'b000;
  assign o_wire_M_AXI_ARQOS   = 4'b0000;

endmodule
`default_nettype wire
